spi_cmd_decoder: RTL



---
 rtl/spi_cmd_decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns the bridge's byte stream into single-cycle register
// read/write strobes with burst auto-increment, and returns read data on data_out.
module spi_cmd_decoder #(
   parameter int ADDR_W   = 6,
   parameter int NUM_REGS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_sync,
   input  logic [7:0]        data_in,
   input  logic              frame_abort,
   output logic [7:0]        data_out,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   input  logic [7:0]        rdata,
   output logic              addr_err
);

   typedef enum logic {ST_CMD, ST_DATA} state_t;

   state_t            state, state_nxt;
   logic              rw, rw_nxt;
   logic              burst, burst_nxt;
   // Access occupying the current cycle, whether its strobe was issued or suppressed.
   logic              rd_acc, rd_acc_nxt;
   logic              wr_acc, wr_acc_nxt;
   logic [ADDR_W-1:0] addr_base, addr_nxt;
   logic [7:0]        wdata_nxt, data_out_nxt;
   logic              read_nxt, write_nxt, addr_err_nxt;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (32'(a) >= NUM_REGS - 1) ? '0 : a + ADDR_W'(1);
   endfunction

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_CMD;
      else     state <= state_nxt;
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      if (frame_abort) begin
         state_nxt = ST_CMD;
      end else if (byte_sync) begin
         case (state)
            ST_CMD:  state_nxt = ST_DATA;
            ST_DATA: if (!burst) state_nxt = ST_CMD;
            default: state_nxt = ST_CMD;
         endcase
      end
   end

   always_comb begin
      rw_nxt     = rw;
      burst_nxt  = burst;
      rd_acc_nxt = 1'b0;
      wr_acc_nxt = 1'b0;
      wdata_nxt  = wdata;
      // Burst writes advance the address once the previous write strobe has gone out.
      addr_base  = (wr_acc && burst) ? addr_inc(addr) : addr;
      addr_nxt   = addr_base;
      data_out_nxt = data_out;
      if (rd_acc) data_out_nxt = read ? rdata : 8'h00;

      if (byte_sync && !frame_abort) begin
         case (state)
            ST_CMD: begin
               rw_nxt     = data_in[7];
               burst_nxt  = data_in[6];
               addr_nxt   = data_in[ADDR_W-1:0];
               rd_acc_nxt = !data_in[7];
            end
            ST_DATA: begin
               if (rw) begin
                  wr_acc_nxt = 1'b1;
                  wdata_nxt  = data_in;
               end else if (burst) begin
                  addr_nxt   = addr_inc(addr_base);
                  rd_acc_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end

      read_nxt     = rd_acc_nxt && in_range(addr_nxt);
      write_nxt    = wr_acc_nxt && in_range(addr_nxt);
      addr_err_nxt = (rd_acc_nxt || wr_acc_nxt) && !in_range(addr_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw       <= 1'b0;
         burst    <= 1'b0;
         rd_acc   <= 1'b0;
         wr_acc   <= 1'b0;
         addr     <= '0;
         wdata    <= 8'h00;
         data_out <= 8'h00;
         read     <= 1'b0;
         write    <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rw       <= rw_nxt;
         burst    <= burst_nxt;
         rd_acc   <= rd_acc_nxt;
         wr_acc   <= wr_acc_nxt;
         addr     <= addr_nxt;
         wdata    <= wdata_nxt;
         data_out <= data_out_nxt;
         read     <= read_nxt;
         write    <= write_nxt;
         addr_err <= addr_err_nxt;
      end
   end

endmodule
